// File: rtl/seq_median6_pkg.sv
// Shared constants and FSM encoding for the six-sample sequential median filter.
package seq_median6_pkg;

  localparam int unsigned N             = 6;
  localparam int unsigned NUM_PHASES    = 6;
  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned CNT_W         = 3;
  localparam int unsigned PHASE_W       = 3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SORT    = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_median6_cmp_swap.sv
// Compare-swap element: lo receives the minimum; equal inputs pass straight through.
module cmp_swap
  import seq_median6_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap_c;

  // Swap only on strict inequality so duplicates keep their order.
  assign swap_c = (b < a);
  assign lo     = swap_c ? b : a;
  assign hi     = swap_c ? a : b;

endmodule

// File: rtl/seq_median6.sv
// Collects six samples, sorts them with an odd-even transposition network
// over six cycles, and presents the mean of the two middle values.
module seq_median6
  import seq_median6_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] median,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               full_q, full_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   median_q, median_d;
  logic [WIDTH-1:0]   buf_q [N];
  logic [WIDTH-1:0]   buf_d [N];
  logic [WIDTH:0]     sum_c;

  logic               odd_c;
  logic [WIDTH-1:0]   a0_c, b0_c, a1_c, b1_c;
  logic [WIDTH-1:0]   lo0_c, hi0_c, lo1_c, hi1_c, lo2_c, hi2_c;

  // Route slot pairs to the shared compare-swap elements by phase parity.
  assign odd_c = phase_q[0];
  assign a0_c  = odd_c ? buf_q[1] : buf_q[0];
  assign b0_c  = odd_c ? buf_q[2] : buf_q[1];
  assign a1_c  = odd_c ? buf_q[3] : buf_q[2];
  assign b1_c  = odd_c ? buf_q[4] : buf_q[3];

  cmp_swap #(.WIDTH(WIDTH)) u_cs0 (.a(a0_c),     .b(b0_c),     .lo(lo0_c), .hi(hi0_c));
  cmp_swap #(.WIDTH(WIDTH)) u_cs1 (.a(a1_c),     .b(b1_c),     .lo(lo1_c), .hi(hi1_c));
  cmp_swap #(.WIDTH(WIDTH)) u_cs2 (.a(buf_q[4]), .b(buf_q[5]), .lo(lo2_c), .hi(hi2_c));

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      phase_q     <= '0;
      full_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      median_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      full_q      <= full_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      median_q    <= median_d;
    end
  end

  // Sample buffer; contents are meaningless after reset so it is not cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      buf_q[i] <= buf_d[i];
    end
  end

  // Next-state, buffer update and median computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    full_d      = full_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    median_d    = median_q;
    sum_c       = '0;
    for (int i = 0; i < int'(N); i++) begin
      buf_d[i] = buf_q[i];
    end

    case (state_q)
      ST_COLLECT: begin
        if (full_q) begin
          // Window complete: start sorting on the cycle after the last accept.
          state_d = ST_SORT;
          phase_d = '0;
          full_d  = 1'b0;
        end else if (in_valid && in_ready_q) begin
          buf_d[cnt_q] = in_data;
          if (cnt_q == CNT_W'(N - 1)) begin
            cnt_d      = '0;
            full_d     = 1'b1;
            in_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_SORT: begin
        if (odd_c) begin
          buf_d[1] = lo0_c;
          buf_d[2] = hi0_c;
          buf_d[3] = lo1_c;
          buf_d[4] = hi1_c;
        end else begin
          buf_d[0] = lo0_c;
          buf_d[1] = hi0_c;
          buf_d[2] = lo1_c;
          buf_d[3] = hi1_c;
          buf_d[4] = lo2_c;
          buf_d[5] = hi2_c;
        end
        if (phase_q == PHASE_W'(NUM_PHASES - 1)) begin
          // Average taken from the fully sorted values at one extra bit of headroom.
          sum_c       = (WIDTH+1)'(buf_d[2]) + (WIDTH+1)'(buf_d[3]);
          median_d    = sum_c[WIDTH:1];
          out_valid_d = 1'b1;
          phase_d     = '0;
          state_d     = ST_OUTPUT;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end

      ST_OUTPUT: begin
        if (out_ready) begin
          state_d     = ST_COLLECT;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign median    = median_q;

endmodule

// File: tb/tb_seq_median6.sv
// Bench for seq_median6: latency-based behavioural model plus directed windows.
module tb_seq_median6;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] median;
  logic         out_valid;
  logic         out_ready;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk    = 1'b0;

  // Model state
  bit m_in_ready;
  bit m_out_valid;
  int m_median;
  int m_win[$];
  int m_held[$];
  int m_wait = -1;

  always #5 clk = ~clk;

  seq_median6 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .median   (median),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic int med6(input int q[$]);
    int s[$];
    s = q;
    s.sort();
    return (s[2] + s[3]) / 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: six accepted samples, then the median appears seven edges later
  // and holds until the consumer takes it.
  always @(posedge clk) begin
    if (rst) begin
      m_win.delete();
      m_in_ready  = 1'b1;
      m_out_valid = 1'b0;
      m_median    = 0;
      m_wait      = -1;
    end else if (m_out_valid) begin
      if (out_ready) begin
        m_out_valid = 1'b0;
        m_in_ready  = 1'b1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_median    = med6(m_held);
        m_out_valid = 1'b1;
        m_wait      = -1;
      end
    end else if (m_in_ready && in_valid) begin
      m_win.push_back(int'(in_data));
      if (m_win.size() == 6) begin
        m_held = m_win;
        m_win.delete();
        m_in_ready = 1'b0;
        m_wait     = 7;
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk) begin
      check("in_ready",  in_ready,  int'(m_in_ready));
      check("out_valid", out_valid, int'(m_out_valid));
      check("median",    median,    m_median);
    end
  end

  task automatic feed6(input int v[6], input bit gap);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = W'(v[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gap && i < 5) begin
        in_data = W'($urandom_range(15, 0));
        @(posedge clk); #1;
      end
    end
  endtask

  // Wait for out_valid (bounded), check literals, hold, then hand-shake.
  task automatic wait_out(input string name, input int lit, input int exp_lat, input int hold);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_valid"}, out_valid, 1);
    if (exp_lat >= 0) check({name, "_latency"}, cyc, exp_lat);
    if (lit >= 0)     check({name, "_median"}, median, lit);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_ready"}, in_ready, 0);
      if (lit >= 0) check({name, "_hold_median"}, median, lit);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_post_ready"}, in_ready, 1);
    check({name, "_post_valid"}, out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[6];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_median",    median,    0);

    // Basic window with latency and a five-cycle consumer stall.
    feed6('{3, 1, 4, 1, 5, 9}, 1'b0);
    wait_out("pi", 3, 7, 5);

    // Saturated values and alternating extremes.
    feed6('{15, 15, 15, 15, 15, 15}, 1'b0);
    wait_out("max", 15, 7, 0);
    feed6('{0, 15, 0, 15, 0, 15}, 1'b0);
    wait_out("alt", 7, 7, 0);

    // Inputs offered during SORT must be ignored.
    feed6('{9, 8, 7, 6, 5, 4}, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 4'd12;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out("desc", 6, -1, 0);

    // Reset during SORT phase 3 discards the window.
    feed6('{1, 2, 3, 4, 5, 6}, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready,  1);
    feed6('{2, 2, 2, 8, 8, 8}, 1'b0);
    wait_out("fresh", 5, 7, 0);

    // Random windows with an in_valid gap pattern.
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(15, 0));
      feed6(v, 1'b1);
      wait_out("rnd", -1, -1, int'($urandom_range(2, 0)));
    end

    @(negedge clk);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
